// File: rtl/bridge_pkg.sv
// Shared AHB bridge definitions: HTRANS encodings and the arbiter FSM state type.
package bridge_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ST_IDLE   = 2'd0;
   localparam arb_state_t ST_OWNED  = 2'd1;
   localparam arb_state_t ST_LOCKED = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// Round-robin masked priority encoder: first set request at or after ptr, wrapping
// modulo NUM_MASTERS.
module rr_pick
   import bridge_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int MW          = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [MW-1:0]          ptr,
   output logic                   valid,
   output logic [MW-1:0]          idx
);

   function automatic logic [MW-1:0] wrap_add(input logic [MW-1:0] base, input int offset);
      logic [MW:0] sum;
      sum = {1'b0, base} + (MW+1)'(offset);
      if (sum >= (MW+1)'(NUM_MASTERS)) sum = sum - (MW+1)'(NUM_MASTERS);
      return MW'(sum);
   endfunction

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      logic [MW-1:0] cand;
      valid = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         cand = wrap_add(ptr, k);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// AHB bridge slave-port arbiter: round-robin grant, burst and lock aware, frozen on Hready=0.
// Optional owner tenure limit enabled by defining ARB_TENURE_EN.
module ahb_bridge_arbiter
   import bridge_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int MW          = $clog2(NUM_MASTERS),
   parameter int MAX_TENURE  = 16
) (
   input  logic                   Hclk,
   input  logic                   Hreset,
   input  logic [NUM_MASTERS-1:0] Hbusreq,
   input  logic [NUM_MASTERS-1:0] Hlock,
   input  logic [1:0]             Htrans,
   input  logic                   Hready,
   output logic [NUM_MASTERS-1:0] Hgrant,
   output logic [MW-1:0]          Hmaster,
   output logic                   Hmastlock
);

   arb_state_t             state_q, next_state;
   logic [NUM_MASTERS-1:0] grant_q;
   logic [MW-1:0]          owner_q;
   logic                   lock_q;
   logic [MW-1:0]          ptr_q;

   logic                   pick_valid;
   logic [MW-1:0]          pick_idx;
   logic [MW:0]            ptr_inc;
   logic [MW-1:0]          next_ptr;
   logic                   arb;
   logic                   owner_req, owner_lock, others_req, boundary, tenure_hit;

   rr_pick #(.NUM_MASTERS(NUM_MASTERS), .MW(MW)) u_pick (
      .req   (Hbusreq),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign owner_req  = Hbusreq[owner_q];
   assign owner_lock = Hlock[owner_q];
   assign others_req = |(Hbusreq & ~grant_q);
   assign boundary   = (Htrans == HTRANS_IDLE) || (Htrans == HTRANS_NONSEQ);
   assign ptr_inc    = {1'b0, pick_idx} + (MW+1)'(1);
   assign next_ptr   = (ptr_inc == (MW+1)'(NUM_MASTERS)) ? '0 : MW'(ptr_inc);

`ifdef ARB_TENURE_EN
   localparam int TW = $clog2(MAX_TENURE + 1);
   logic [TW-1:0] tenure_q;

   // Counts only contested OWNED cycles; saturates so the force stays asserted.
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         tenure_q <= '0;
      end else if (Hready) begin
         if (arb) begin
            tenure_q <= '0;
         end else if (state_q == ST_OWNED && others_req && tenure_q != TW'(MAX_TENURE)) begin
            tenure_q <= tenure_q + TW'(1);
         end
      end
   end

   assign tenure_hit = (tenure_q == TW'(MAX_TENURE));
`else
   // Tenure is unbounded; the parameter only keeps the interface uniform.
   assign tenure_hit = 1'b0 & (MAX_TENURE > 0);
`endif

   always_comb begin
      arb        = 1'b0;
      next_state = state_q;
      case (state_q)
         ST_IDLE:   arb = 1'b1;
         ST_OWNED: begin
            if (owner_lock) next_state = ST_LOCKED;
            else if (boundary && (!owner_req || tenure_hit)) arb = 1'b1;
         end
         ST_LOCKED: begin
            if (!owner_lock && Htrans == HTRANS_IDLE) begin
               if (owner_req) next_state = ST_OWNED;
               else           arb        = 1'b1;
            end
         end
         default:   next_state = ST_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         owner_q <= '0;
         lock_q  <= 1'b0;
         ptr_q   <= '0;
      end else if (Hready) begin
         if (arb) begin
            if (pick_valid) begin
               grant_q <= NUM_MASTERS'(1) << pick_idx;
               owner_q <= pick_idx;
               ptr_q   <= next_ptr;
               lock_q  <= Hlock[pick_idx];
               state_q <= Hlock[pick_idx] ? ST_LOCKED : ST_OWNED;
            end else begin
               grant_q <= '0;
               lock_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         end else begin
            state_q <= next_state;
            lock_q  <= (next_state == ST_LOCKED);
         end
      end
   end

   assign Hgrant    = grant_q;
   assign Hmaster   = owner_q;
   assign Hmastlock = lock_q;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Self-checking bench for ahb_bridge_arbiter: directed scenarios plus randomized traffic
// against a behavioural arbiter model.
module tb_ahb_bridge_arbiter;

   localparam int N     = 4;
   localparam int MAX_T = 16;

   logic         Hclk = 1'b0;
   logic         Hreset;
   logic [N-1:0] Hbusreq, Hlock;
   logic [1:0]   Htrans;
   logic         Hready;
   logic [N-1:0] Hgrant;
   logic [1:0]   Hmaster;
   logic         Hmastlock;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: owner (-1 = none), last owner, lock flag, search start, tenure.
   int m_owner, m_last, m_ptr, m_ten;
   bit m_locked;

   ahb_bridge_arbiter #(.NUM_MASTERS(N), .MAX_TENURE(MAX_T)) dut (
      .Hclk      (Hclk),
      .Hreset    (Hreset),
      .Hbusreq   (Hbusreq),
      .Hlock     (Hlock),
      .Htrans    (Htrans),
      .Hready    (Hready),
      .Hgrant    (Hgrant),
      .Hmaster   (Hmaster),
      .Hmastlock (Hmastlock)
   );

   always #5 Hclk = ~Hclk;

   function automatic int model_pick(logic [N-1:0] req, int start);
      for (int k = 0; k < N; k++)
         if (req[(start + k) % N]) return (start + k) % N;
      return -1;
   endfunction

   task automatic model_step();
      int idx;
      bit rearb, forced, bnd;
      logic [N-1:0] others;
      if (Hreset) begin
         m_owner = -1; m_last = 0; m_ptr = 0; m_ten = 0; m_locked = 0;
         return;
      end
      if (!Hready) return;
      bnd   = (Htrans == 2'b00) || (Htrans == 2'b10);
      rearb = 0;
      if (m_owner < 0) begin
         rearb = 1;
      end else if (m_locked) begin
         if (!Hlock[m_owner] && Htrans == 2'b00) begin
            if (Hbusreq[m_owner]) m_locked = 0;
            else                  rearb = 1;
         end
      end else begin
`ifdef ARB_TENURE_EN
         forced = (m_ten >= MAX_T);
`else
         forced = 0;
`endif
         if (Hlock[m_owner])                              m_locked = 1;
         else if (bnd && (!Hbusreq[m_owner] || forced))   rearb = 1;
         others = Hbusreq;
         others[m_owner] = 1'b0;
         if (!rearb && others != 0 && m_ten < MAX_T) m_ten++;
      end
      if (rearb) begin
         m_ten = 0;
         idx   = model_pick(Hbusreq, m_ptr);
         if (idx < 0) begin
            m_owner = -1; m_locked = 0;
         end else begin
            m_owner = idx; m_last = idx; m_ptr = (idx + 1) % N; m_locked = Hlock[idx];
         end
      end
   endtask

   function automatic logic [6:0] model_vec();
      logic [N-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return {g, 2'(m_last), (m_locked && m_owner >= 0)};
   endfunction

   task automatic tick();
      @(posedge Hclk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      Hreset = 1'b1; Hready = 1'b0; Hbusreq = 4'b1111; Hlock = 4'b1111; Htrans = 2'b10;
      tick();
      n_cmp++;
      if ({Hgrant, Hmaster, Hmastlock} !== 7'b0000_00_0) begin
         n_bad++;
         $display("FAIL reset: got grant=%b master=%0d lock=%b, want 0000/0/0", Hgrant, Hmaster, Hmastlock);
      end
      Hreset = 1'b0; Hlock = '0; Hbusreq = '0; Htrans = 2'b00;
   endtask

   task automatic test_first_grant();
      Hready = 1'b1; Hbusreq = 4'b0100;
      tick();
      n_cmp++;
      if ({Hgrant, Hmaster, Hmastlock} !== {4'b0100, 2'd2, 1'b0}) begin
         n_bad++;
         $display("FAIL first_grant: got grant=%b master=%0d lock=%b, want 0100/2/0", Hgrant, Hmaster, Hmastlock);
      end
   endtask

   task automatic test_rotation();
      logic [N-1:0] req_t [3] = '{4'b1011, 4'b0011, 4'b0010};
      logic [6:0]   exp_t [3] = '{{4'b1000, 2'd3, 1'b0}, {4'b0001, 2'd0, 1'b0}, {4'b0010, 2'd1, 1'b0}};
      Htrans = 2'b00;
      for (int i = 0; i < 3; i++) begin
         Hbusreq = req_t[i];
         tick();
         n_cmp++;
         if ({Hgrant, Hmaster, Hmastlock} !== exp_t[i]) begin
            n_bad++;
            $display("FAIL rotation[%0d]: got %b/%0d/%b, want %b", i, Hgrant, Hmaster, Hmastlock, exp_t[i]);
         end
      end
   endtask

   task automatic test_burst_hold();
      logic [1:0] tr_t  [5] = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b10};
      logic [6:0] exp_t [5] = '{{4'b0010, 2'd1, 1'b0}, {4'b0010, 2'd1, 1'b0}, {4'b0010, 2'd1, 1'b0},
                                {4'b0010, 2'd1, 1'b0}, {4'b0001, 2'd0, 1'b0}};
      Hbusreq = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         Htrans = tr_t[i];
         tick();
         n_cmp++;
         if ({Hgrant, Hmaster, Hmastlock} !== exp_t[i]) begin
            n_bad++;
            $display("FAIL burst_hold[%0d]: got %b/%0d/%b, want %b", i, Hgrant, Hmaster, Hmastlock, exp_t[i]);
         end
      end
   endtask

   task automatic test_ready_stall();
      Hready = 1'b0; Htrans = 2'b00; Hbusreq = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) Hbusreq = 4'b1010;
         if (i == 3) Hbusreq = 4'b1000;
         tick();
         n_cmp++;
         if ({Hgrant, Hmaster, Hmastlock} !== {4'b0001, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL ready_stall[%0d]: got %b/%0d/%b, want 0001/0/0", i, Hgrant, Hmaster, Hmastlock);
         end
      end
      Hready = 1'b1;
      tick();
      n_cmp++;
      if ({Hgrant, Hmaster, Hmastlock} !== {4'b1000, 2'd3, 1'b0}) begin
         n_bad++;
         $display("FAIL ready_resume: got %b/%0d/%b, want 1000/3/0", Hgrant, Hmaster, Hmastlock);
      end
   endtask

   task automatic test_regrant_hold();
      Hbusreq = 4'b1000;
      for (int i = 0; i < 3; i++) begin
         Htrans = (i == 1) ? 2'b10 : 2'b00;
         tick();
         n_cmp++;
         if ({Hgrant, Hmaster, Hmastlock} !== {4'b1000, 2'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL regrant_hold[%0d]: got %b/%0d/%b, want 1000/3/0", i, Hgrant, Hmaster, Hmastlock);
         end
      end
   endtask

   task automatic test_lock();
      logic [N-1:0] req_t [6] = '{4'b0001, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110};
      logic [N-1:0] lck_t [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
      logic [1:0]   tr_t  [6] = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00};
      logic [6:0]   exp_t [6] = '{{4'b0001, 2'd0, 1'b1}, {4'b0001, 2'd0, 1'b1}, {4'b0001, 2'd0, 1'b1},
                                  {4'b0001, 2'd0, 1'b1}, {4'b0001, 2'd0, 1'b1}, {4'b0010, 2'd1, 1'b0}};
      for (int i = 0; i < 6; i++) begin
         Hbusreq = req_t[i]; Hlock = lck_t[i]; Htrans = tr_t[i];
         tick();
         n_cmp++;
         if ({Hgrant, Hmaster, Hmastlock} !== exp_t[i]) begin
            n_bad++;
            $display("FAIL lock[%0d]: got %b/%0d/%b, want %b", i, Hgrant, Hmaster, Hmastlock, exp_t[i]);
         end
      end
   endtask

   task automatic test_idle_return();
      Hbusreq = '0; Hlock = '0; Htrans = 2'b00;
      tick();
      n_cmp++;
      if ({Hgrant, Hmaster, Hmastlock} !== {4'b0000, 2'd1, 1'b0}) begin
         n_bad++;
         $display("FAIL idle_return: got %b/%0d/%b, want 0000/1/0", Hgrant, Hmaster, Hmastlock);
      end
   endtask

   task automatic test_reset_mid_tenure();
      Hbusreq = 4'b0100; Hlock = 4'b0100;
      tick();
      n_cmp++;
      if ({Hgrant, Hmaster, Hmastlock} !== {4'b0100, 2'd2, 1'b1}) begin
         n_bad++;
         $display("FAIL locked_grant: got %b/%0d/%b, want 0100/2/1", Hgrant, Hmaster, Hmastlock);
      end
      Hready = 1'b0; Hreset = 1'b1;
      tick();
      n_cmp++;
      if ({Hgrant, Hmaster, Hmastlock} !== 7'b0000_00_0) begin
         n_bad++;
         $display("FAIL reset_mid: got %b/%0d/%b, want 0000/0/0", Hgrant, Hmaster, Hmastlock);
      end
      Hreset = 1'b0; Hready = 1'b1; Hlock = '0; Hbusreq = 4'b1001;
      tick();
      n_cmp++;
      if ({Hgrant, Hmaster, Hmastlock} !== {4'b0001, 2'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL post_reset_grant: got %b/%0d/%b, want 0001/0/0", Hgrant, Hmaster, Hmastlock);
      end
   endtask

   task automatic test_tenure();
      Hbusreq = 4'b1001; Htrans = 2'b00;
`ifdef ARB_TENURE_EN
      for (int i = 0; i < MAX_T; i++) begin
         tick();
         n_cmp++;
         if (Hgrant !== 4'b0001) begin
            n_bad++;
            $display("FAIL tenure_hold[%0d]: got grant=%b, want 0001", i, Hgrant);
         end
      end
      tick();
      n_cmp++;
      if ({Hgrant, Hmaster} !== {4'b1000, 2'd3}) begin
         n_bad++;
         $display("FAIL tenure_force: got %b/%0d, want 1000/3", Hgrant, Hmaster);
      end
`else
      for (int i = 0; i < MAX_T + 8; i++) begin
         tick();
         n_cmp++;
         if (Hgrant !== 4'b0001) begin
            n_bad++;
            $display("FAIL tenure_unbounded[%0d]: got grant=%b, want 0001", i, Hgrant);
         end
      end
`endif
   endtask

   task automatic test_random();
      logic [6:0] exp;
      Hreset = 1'b1;
      tick();
      Hreset = 1'b0;
      for (int i = 0; i < 600; i++) begin
         Hreset  = ($urandom_range(0, 79) == 0);
         Hready  = ($urandom_range(0, 4) != 0);
         Hbusreq = N'($urandom);
         Hlock   = ($urandom_range(0, 3) == 0) ? (Hbusreq & N'($urandom)) : '0;
         Htrans  = 2'($urandom);
         tick();
         exp = model_vec();
         n_cmp++;
         if ({Hgrant, Hmaster, Hmastlock} !== exp) begin
            n_bad++;
            $display("FAIL random[%0d]: got %b/%0d/%b, want %b", i, Hgrant, Hmaster, Hmastlock, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_grant();
      test_rotation();
      test_burst_hold();
      test_ready_stall();
      test_regrant_hold();
      test_lock();
      test_idle_return();
      test_reset_mid_tenure();
      test_tenure();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
